// File: rtl/info_panel_dd.sv
// info_panel_dd
//   Text panel: each row is one field. The left columns of a row show a label;
//   the right columns show the field's binary value in decimal. A single
//   double-dabble engine converts the fields one after another, taking
//   BIN_W+2 cycles per field. The results are kept in a digit cache, and the
//   character lookup reads only that cache.
//
// Ports
//   pclk       pixel clock; all logic runs on the rising edge
//   rst_n      synchronous active-low reset
//   char_xy    [7:4] row (field), [3:0] column
//   values     field k at [k*BIN_W +: BIN_W]
//   labels     char (k,c) at [(k*LABEL_LEN+c)*7 +: 7]
//   freeze     1: finish the current field, then hold all digits
//   char_code  registered character code for the font ROM (1-cycle latency)
//   busy       engine is in LOAD/SHIFT/COMMIT
//   all_valid  every field has been converted at least once since reset
//   ovf        field k value was >= 10**DIGITS at its last commit
module info_panel_dd #(
    parameter int N_FIELDS = 3,
    parameter int BIN_W    = 24,
    parameter int DIGITS   = 6,
    parameter bit BLANK_LZ = 1'b0
) (
    input  logic                                                  pclk,
    input  logic                                                  rst_n,
    input  logic [7:0]                                            char_xy,
    input  logic [N_FIELDS*BIN_W-1:0]                             values,
    input  logic [N_FIELDS*((DIGITS < 16) ? (16-DIGITS) : 1)*7-1:0] labels,
    input  logic                                                  freeze,
    output logic [6:0]                                            char_code,
    output logic                                                  busy,
    output logic                                                  all_valid,
    output logic [N_FIELDS-1:0]                                   ovf
);

    localparam int LABEL_LEN = 16 - DIGITS;
    // Label stride; kept at least 1 so the port stays legal when DIGITS=16.
    localparam int LBL_W     = (LABEL_LEN > 0) ? LABEL_LEN : 1;
    localparam int BCD_W     = DIGITS * 4;
    localparam int PTR_W     = (N_FIELDS > 1) ? $clog2(N_FIELDS) : 1;
    localparam int CNT_W     = $clog2(BIN_W + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(N_FIELDS - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LOAD   = 2'd1;
    localparam logic [1:0] ST_SHIFT  = 2'd2;
    localparam logic [1:0] ST_COMMIT = 2'd3;

    logic [1:0]          state_q, state_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [BIN_W-1:0]    sh_q, sh_d;
    logic [BCD_W-1:0]    bcd_q, bcd_d;
    logic                carry_q, carry_d;
    logic                commit;
    logic [BCD_W-1:0]    adj;

    logic [BCD_W-1:0]    cache_q [N_FIELDS];
    logic [N_FIELDS-1:0] ovf_q;
    logic [N_FIELDS-1:0] valid_q;
    logic [6:0]          char_code_q, char_d;

    int                  row_i, col_i, di;
    logic [PTR_W-1:0]    row_sel;
    logic [BCD_W-1:0]    row_bits;
    logic [3:0]          nib;
    logic                upper_nz;

    // Double-dabble correction: any nibble >= 5 gets +3 so that the shift
    // which follows carries correctly into the next decimal digit.
    function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] b);
        logic [BCD_W-1:0] r;
        r = b;
        for (int i = 0; i < DIGITS; i++) begin
            if (b[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = b[i*4 +: 4] + 4'd3;
        end
        return r;
    endfunction

    // Conversion engine next-state logic
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        bcd_d   = bcd_q;
        carry_d = carry_q;
        commit  = 1'b0;
        adj     = add3(bcd_q);
        case (state_q)
            ST_IDLE: begin
                if (!freeze) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                // Only this snapshot is used, so the input may change freely
                // during SHIFT without tearing the displayed digits.
                sh_d    = BIN_W'(values >> (int'(ptr_q) * BIN_W));
                bcd_d   = '0;
                carry_d = 1'b0;
                cnt_d   = '0;
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                bcd_d   = {adj[BCD_W-2:0], sh_q[BIN_W-1]};
                // A bit leaving the top nibble means value >= 10**DIGITS.
                carry_d = carry_q | adj[BCD_W-1];
                sh_d    = sh_q << 1;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) state_d = ST_COMMIT;
            end
            default: begin
                commit  = 1'b1;
                ptr_d   = (ptr_q == PTR_LAST) ? '0 : ptr_q + 1'b1;
                state_d = freeze ? ST_IDLE : ST_LOAD;
            end
        endcase
    end

    // Character lookup, driven from the cache only
    always_comb begin
        char_d   = '0;
        row_i    = int'(char_xy[7:4]);
        col_i    = int'(char_xy[3:0]);
        di       = 15 - col_i;
        row_sel  = PTR_W'(row_i);
        row_bits = '0;
        nib      = '0;
        upper_nz = 1'b0;
        if (row_i < N_FIELDS) begin
            if (col_i < LABEL_LEN) begin
                char_d = 7'(labels >> ((row_i * LBL_W + col_i) * 7));
            end else begin
                row_bits = cache_q[row_sel];
                nib      = 4'(row_bits >> (di * 4));
                // Nonzero if this digit or any more-significant digit is set.
                upper_nz = ((row_bits >> (di * 4)) != '0);
                if (ovf_q[row_sel])
                    char_d = 7'h39;
                else if (BLANK_LZ && !upper_nz && (di != 0))
                    char_d = 7'h00;
                else
                    char_d = {3'b000, nib} + 7'h30;
            end
        end
    end

    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            cnt_q       <= '0;
            sh_q        <= '0;
            bcd_q       <= '0;
            carry_q     <= 1'b0;
            ovf_q       <= '0;
            valid_q     <= '0;
            char_code_q <= '0;
            for (int k = 0; k < N_FIELDS; k++) cache_q[k] <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            sh_q        <= sh_d;
            bcd_q       <= bcd_d;
            carry_q     <= carry_d;
            char_code_q <= char_d;
            // Digits, overflow and valid are updated together.
            if (commit) begin
                cache_q[ptr_q] <= bcd_q;
                ovf_q[ptr_q]   <= carry_q;
                valid_q[ptr_q] <= 1'b1;
            end
        end
    end

    assign char_code = char_code_q;
    assign busy      = (state_q != ST_IDLE);
    assign all_valid = &valid_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_info_panel_dd.sv
module tb_info_panel_dd;
    localparam int     NF  = 3;
    localparam int     BW  = 24;
    localparam int     DG  = 6;
    localparam int     LL  = 16 - DG;
    localparam longint LIM = 64'd1000000;

    logic            pclk = 1'b0;
    logic            rst_n = 1'b0;
    logic            freeze = 1'b0;
    logic [7:0]      char_xy = 8'h00;
    logic [NF*BW-1:0]   values = '0;
    logic [NF*LL*7-1:0] labels = '0;
    logic [6:0]      cc_a, cc_b;
    logic            busy_a, busy_b, av_a, av_b;
    logic [NF-1:0]   ovf_a, ovf_b;

    int     total = 0;
    int     bad = 0;
    int     cyc = 0;
    longint mv [NF];

    always #5 pclk = ~pclk;

    info_panel_dd #(.N_FIELDS(NF), .BIN_W(BW), .DIGITS(DG), .BLANK_LZ(1'b0)) dut_a (
        .pclk(pclk), .rst_n(rst_n), .char_xy(char_xy), .values(values), .labels(labels),
        .freeze(freeze), .char_code(cc_a), .busy(busy_a), .all_valid(av_a), .ovf(ovf_a));

    info_panel_dd #(.N_FIELDS(NF), .BIN_W(BW), .DIGITS(DG), .BLANK_LZ(1'b1)) dut_b (
        .pclk(pclk), .rst_n(rst_n), .char_xy(char_xy), .values(values), .labels(labels),
        .freeze(freeze), .char_code(cc_b), .busy(busy_b), .all_valid(av_b), .ovf(ovf_b));

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge pclk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: decimal digit di (0 = least significant) as displayed.
    function automatic logic [6:0] exp_char(input longint v, input int di, input bit blank);
        longint p;
        p = 1;
        for (int i = 0; i < di; i++) p = p * 10;
        if (v >= LIM) return 7'h39;
        if (blank && di != 0 && (v / p) == 0) return 7'h00;
        return 7'(64'h30 + (v / p) % 10);
    endfunction

    function automatic logic [6:0] lbl(input int k, input int c);
        return labels[(k*LL + c)*7 +: 7];
    endfunction

    task automatic set_val(input int k, input longint v);
        values[k*BW +: BW] = v[BW-1:0];
    endtask

    task automatic rd(input int r, input int c, output logic [6:0] a, output logic [6:0] b);
        char_xy = {4'(r), 4'(c)};
        tick();
        a = cc_a;
        b = cc_b;
    endtask

    task automatic check_row(input int k, input string tag);
        logic [6:0] a, b;
        for (int c = LL; c < 16; c++) begin
            rd(k, c, a, b);
            chk($sformatf("%s_r%0dc%0d_a", tag, k, c), a, exp_char(mv[k], 15 - c, 1'b0));
            chk($sformatf("%s_r%0dc%0d_b", tag, k, c), b, exp_char(mv[k], 15 - c, 1'b1));
        end
        chk($sformatf("%s_ovf%0d_a", tag, k), ovf_a[k], (mv[k] >= LIM) ? 1 : 0);
        chk($sformatf("%s_ovf%0d_b", tag, k), ovf_b[k], (mv[k] >= LIM) ? 1 : 0);
    endtask

    // Any field picks up a new input within one sweep plus one field time.
    task automatic settle();
        repeat (NF*(BW+2) + BW + 2) tick();
        for (int k = 0; k < NF; k++) mv[k] = longint'(values[k*BW +: BW]);
    endtask

    initial begin
        logic [6:0] a, b;
        longint v, snap;
        longint v6 [NF];
        int L, F;

        for (int i = 0; i < NF*LL; i++) labels[i*7 +: 7] = 7'($urandom_range(33, 126));
        set_val(0, 0); set_val(1, 500); set_val(2, 123456);

        // reset state
        rst_n = 1'b0; char_xy = 8'h00;
        tick(); tick();
        chk("rst_cc_a", cc_a, 0);      chk("rst_cc_b", cc_b, 0);
        chk("rst_busy_a", busy_a, 0);  chk("rst_av_a", av_a, 0);
        chk("rst_ovf_a", ovf_a, 0);    chk("rst_ovf_b", ovf_b, 0);
        rst_n = 1'b1; cyc = 0;
        for (int k = 0; k < NF; k++) mv[k] = 0;
        tick();
        chk("busy_load_a", busy_a, 1); chk("busy_load_b", busy_b, 1);

        // before any commit, label path and out-of-range rows
        rd(0, 15, a, b); chk("pre_lsd_a", a, 7'h30); chk("pre_lsd_b", b, 7'h30);
        rd(0, 10, a, b); chk("pre_msd_a", a, 7'h30); chk("pre_msd_b", b, 7'h00);
        rd(0, 0, a, b);  chk("lbl00_a", a, lbl(0, 0)); chk("lbl00_b", b, lbl(0, 0));
        rd(2, 9, a, b);  chk("lbl29_a", a, lbl(2, 9));
        char_xy = 8'h30; tick(); chk("row3_a", cc_a, 0); chk("row3_b", cc_b, 0);
        char_xy = 8'h05; #2; chk("latency_hold", cc_a, 0);
        tick(); chk("latency_new", cc_a, lbl(0, 5));
        rd(15, 15, a, b); chk("row15_a", a, 0);
        check_row(2, "pre");

        // first sweep timing and test-1 values
        while (cyc < 78) tick();
        chk("av_before_a", av_a, 0);
        tick();
        chk("av_after_a", av_a, 1); chk("av_after_b", av_b, 1);
        mv[0] = 0; mv[1] = 500; mv[2] = 123456;
        for (int k = NF-1; k >= 0; k--) check_row(k, "t1");

        // blanking with a small value
        set_val(0, 42); settle(); check_row(0, "t2");

        // overflow boundary
        set_val(1, 1000000); settle(); check_row(1, "t3ovf");
        set_val(1, 999999);  settle(); check_row(1, "t3max");
        set_val(1, (1 << 24) - 1); settle(); check_row(1, "t3full");

        // random values
        repeat (4) begin
            for (int k = 0; k < NF; k++) begin
                case ($urandom_range(0, 3))
                    0: v = $urandom_range(0, 99);
                    1: v = $urandom_range(0, 999999);
                    2: v = $urandom_range(999990, 1000009);
                    default: v = $urandom_range(0, (1 << 24) - 1);
                endcase
                set_val(k, v);
            end
            settle();
            for (int k = 0; k < NF; k++) check_row(k, "rnd");
        end

        // field 2 changes every cycle; only the LOAD-edge value may appear
        L = 53;
        while (L < cyc + 12) L += 78;
        while (cyc < L - 10) tick();
        snap = 0;
        while (cyc <= L + 20) begin
            v = $urandom_range(0, 999999);
            set_val(2, v);
            if (cyc == L) snap = v;
            tick();
        end
        while (cyc < L + 26) tick();
        mv[2] = snap;
        check_row(2, "t4");

        // reset in the middle of SHIFT
        set_val(0, 5000000); set_val(1, 999999);
        settle();
        chk("t5_pre_av", av_a, 1); chk("t5_pre_ovf0", ovf_a[0], 1);
        char_xy = 8'h00;
        L = 1;
        while (L + 10 < cyc + 1) L += 26;
        while (cyc < L + 10) tick();
        chk("t5_pre_cc", cc_a, lbl(0, 0));
        rst_n = 1'b0;
        tick();
        chk("t5_cc_a", cc_a, 0);     chk("t5_cc_b", cc_b, 0);
        chk("t5_busy_a", busy_a, 0); chk("t5_av_a", av_a, 0);
        chk("t5_ovf_a", ovf_a, 0);   chk("t5_ovf_b", ovf_b, 0);
        set_val(0, 2000000); set_val(1, 7777); set_val(2, 55);
        rst_n = 1'b1; cyc = 0;
        for (int k = 0; k < NF; k++) mv[k] = 0;
        while (cyc < 26) tick();
        chk("t5_ovf_c26", ovf_a, 3'b000);
        tick();
        chk("t5_ovf_c27", ovf_a, 3'b001);
        chk("t5_av_c27", av_a, 0);
        mv[0] = 2000000;
        check_row(0, "t5r0");
        check_row(1, "t5r1");

        // freeze during SHIFT of field 2
        while (cyc < 45) tick();
        for (int k = 0; k < NF; k++) begin
            v6[k] = $urandom_range(0, 999999);
            set_val(k, v6[k]);
        end
        L = 53;
        while (cyc < L + 5) tick();
        freeze = 1'b1;
        while (cyc < L + 25) tick();
        chk("t6_busy_commit", busy_a, 1);
        tick();
        chk("t6_busy_idle_a", busy_a, 0); chk("t6_busy_idle_b", busy_b, 0);
        mv[1] = 7777; mv[2] = v6[2];
        set_val(0, 4321); set_val(1, 9000000); set_val(2, $urandom_range(0, 999999));
        repeat (30) tick();
        chk("t6_frozen_busy", busy_a, 0);
        for (int k = 0; k < NF; k++) check_row(k, "t6hold");
        F = cyc;
        freeze = 1'b0;
        chk("t6_unfreeze_idle", busy_a, 0);
        tick();
        chk("t6_resume_busy", busy_a, 1);
        while (cyc < F + 26) tick();
        chk("t6_ovf_before", ovf_a, 3'b001);
        tick();
        chk("t6_ovf_after", ovf_a, 3'b000);
        mv[0] = 4321;
        check_row(0, "t6r0");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
